// File: rtl/bus_pkg_team1.sv
// ---------------------------------------------------------------------------
// bus_pkg_team1
// Shared definitions for the 16-bit common bus of the single-purpose
// processor. Both the bus source multiplexer and the destination register
// bank import this package so they agree on widths and on the meaning of
// the source select code.
//
// Contents:
//   ADDR_W      width of the address registers (AR, PC)
//   DATA_W      width of the bus and of DR, AC, IR, TR
//   bus_sel_e   bus source select encoding (AR .. MEM)
//   reg_ctrl_t  per-register control bundle {ld, inc, clr}
// ---------------------------------------------------------------------------
package bus_pkg_team1;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    // Source select code driven into the bus multiplexer. Code 0 leaves the
    // bus idle; the destination side never decodes this, it only shares it.
    typedef enum logic [2:0] {
        SEL_NONE = 3'b000,
        SEL_AR   = 3'b001,
        SEL_PC   = 3'b010,
        SEL_DR   = 3'b011,
        SEL_AC   = 3'b100,
        SEL_IR   = 3'b101,
        SEL_TR   = 3'b110,
        SEL_MEM  = 3'b111
    } bus_sel_e;

    // Control bundle for one destination register.
    typedef struct packed {
        logic ld;
        logic inc;
        logic clr;
    } reg_ctrl_t;

endpackage

// File: rtl/reg_ldinc_team1.sv
// ---------------------------------------------------------------------------
// reg_ldinc_team1
// General-purpose register with clear, parallel load and increment.
// Priority per edge: clr > ld > inc > hold. The increment wraps modulo
// 2^WIDTH and has no carry out.
//
// Parameters:
//   WIDTH      register width
//   RESET_VAL  value forced by rst
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   d     in   WIDTH  parallel load data
//   ld    in   load d
//   inc   in   increment
//   clr   in   clear to zero
//   q     out  WIDTH  registered value
// ---------------------------------------------------------------------------
module reg_ldinc_team1 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // Register update. Reset beats every control; after that the if/else
    // chain itself encodes the clr > ld > inc > hold priority, so several
    // controls asserted together resolve without extra decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_dest_regs_team1.sv
// ---------------------------------------------------------------------------
// bus_dest_regs_team1
// Destination-side register bank on the 16-bit common bus. Holds AR, PC,
// DR, AC, IR and TR; every register captures bus_in on the rising edge when
// its ld is high, so several registers may load the same word at once. The
// register outputs feed back into the bus multiplexer's source inputs.
//
// Parameters:
//   ADDR_W    width of AR and PC (default 12)
//   DATA_W    width of bus, DR, AC, IR, TR (default 16)
//   PC_RESET  PC value after reset
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bus_in        in  DATA_W     common bus word
//   ld_/inc_/clr_ X in  1 each   per-register controls (IR has ld only)
//   out_AR,out_PC out ADDR_W     registered address registers
//   out_DR,out_AC,out_IR,out_TR  out DATA_W registered data registers
//   ld_any        out 1          high the cycle after any ld_* was sampled
// ---------------------------------------------------------------------------
module bus_dest_regs_team1
    import bus_pkg_team1::*;
#(
    parameter int                ADDR_W   = bus_pkg_team1::ADDR_W,
    parameter int                DATA_W   = bus_pkg_team1::DATA_W,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_AR,
    input  logic              inc_AR,
    input  logic              clr_AR,
    input  logic              ld_PC,
    input  logic              inc_PC,
    input  logic              clr_PC,
    input  logic              ld_DR,
    input  logic              inc_DR,
    input  logic              clr_DR,
    input  logic              ld_AC,
    input  logic              inc_AC,
    input  logic              clr_AC,
    input  logic              ld_IR,
    input  logic              ld_TR,
    input  logic              inc_TR,
    input  logic              clr_TR,
    output logic [ADDR_W-1:0] out_AR,
    output logic [ADDR_W-1:0] out_PC,
    output logic [DATA_W-1:0] out_DR,
    output logic [DATA_W-1:0] out_AC,
    output logic [DATA_W-1:0] out_IR,
    output logic [DATA_W-1:0] out_TR,
    output logic              ld_any
);

    reg_ctrl_t ctrl_ar, ctrl_pc, ctrl_dr, ctrl_ac, ctrl_ir, ctrl_tr;

    // The address registers only see the low ADDR_W bits of the bus.
    logic [ADDR_W-1:0] bus_addr;

    assign bus_addr = bus_in[ADDR_W-1:0];

    assign ctrl_ar = '{ld: ld_AR, inc: inc_AR, clr: clr_AR};
    assign ctrl_pc = '{ld: ld_PC, inc: inc_PC, clr: clr_PC};
    assign ctrl_dr = '{ld: ld_DR, inc: inc_DR, clr: clr_DR};
    assign ctrl_ac = '{ld: ld_AC, inc: inc_AC, clr: clr_AC};
    // IR is load-only.
    assign ctrl_ir = '{ld: ld_IR, inc: 1'b0,   clr: 1'b0};
    assign ctrl_tr = '{ld: ld_TR, inc: inc_TR, clr: clr_TR};

    reg_ldinc_team1 #(.WIDTH(ADDR_W), .RESET_VAL('0)) u_ar (
        .clk(clk), .rst(rst), .d(bus_addr),
        .ld(ctrl_ar.ld), .inc(ctrl_ar.inc), .clr(ctrl_ar.clr), .q(out_AR)
    );

    reg_ldinc_team1 #(.WIDTH(ADDR_W), .RESET_VAL(PC_RESET)) u_pc (
        .clk(clk), .rst(rst), .d(bus_addr),
        .ld(ctrl_pc.ld), .inc(ctrl_pc.inc), .clr(ctrl_pc.clr), .q(out_PC)
    );

    reg_ldinc_team1 #(.WIDTH(DATA_W), .RESET_VAL('0)) u_dr (
        .clk(clk), .rst(rst), .d(bus_in),
        .ld(ctrl_dr.ld), .inc(ctrl_dr.inc), .clr(ctrl_dr.clr), .q(out_DR)
    );

    reg_ldinc_team1 #(.WIDTH(DATA_W), .RESET_VAL('0)) u_ac (
        .clk(clk), .rst(rst), .d(bus_in),
        .ld(ctrl_ac.ld), .inc(ctrl_ac.inc), .clr(ctrl_ac.clr), .q(out_AC)
    );

    reg_ldinc_team1 #(.WIDTH(DATA_W), .RESET_VAL('0)) u_ir (
        .clk(clk), .rst(rst), .d(bus_in),
        .ld(ctrl_ir.ld), .inc(ctrl_ir.inc), .clr(ctrl_ir.clr), .q(out_IR)
    );

    reg_ldinc_team1 #(.WIDTH(DATA_W), .RESET_VAL('0)) u_tr (
        .clk(clk), .rst(rst), .d(bus_in),
        .ld(ctrl_tr.ld), .inc(ctrl_tr.inc), .clr(ctrl_tr.clr), .q(out_TR)
    );

    // Load indicator. Registered so it lines up with the newly captured
    // register values; clr and inc do not count as loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_any <= 1'b0;
        end else begin
            ld_any <= ctrl_ar.ld | ctrl_pc.ld | ctrl_dr.ld |
                      ctrl_ac.ld | ctrl_ir.ld | ctrl_tr.ld;
        end
    end

endmodule
